// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam int CTR_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

  // Clears the low address bits that a half or word access cannot use.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_HALF: return {a[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow store data is replicated so every enabled lane sees it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] ctr);
    logic [31:0] sh;
    logic        uns;
    sh  = word >> {lane, 3'b000};
    uns = ctr[CTR_UNSIGNED_BIT];
    case (ctr[1:0])
      SZ_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dmem_byte_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with WAIT_CYCLES wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  ctr_q, ctr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;

  logic        enter_resp;
  logic        err_d;
  logic [1:0]  lane_d, lane_q;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;

  assign req_ready = (state_q == ST_IDLE) && !rst;

  // Decode the request that is (or is about to be) held; with zero wait
  // states the array is accessed on the same edge that latches it.
  always_comb begin
    logic word_oor;
    word_oor = {2'b00, addr_d[31:2]} >= 32'(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
    err_d  = word_oor || (ctr_d[1:0] == SZ_RSVD) || misaligned(ctr_d[1:0], addr_d[1:0]);
    lane_d = addr_d[1:0];
    lane_q = addr_q[1:0];
`else
    err_d  = word_oor || (ctr_d[1:0] == SZ_RSVD);
    lane_d = force_align(ctr_d[1:0], addr_d[1:0]);
    lane_q = force_align(ctr_q[1:0], addr_q[1:0]);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ctr_d       = ctr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    enter_resp  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_load_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          ctr_d   = req_ctr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_d;
      rsp_load_d  = !we_d && !err_d;
    end
  end

  // Reset on the RESP-entry edge must suppress the write.
  assign mem_we = enter_resp && we_d && !err_d && !rst;
  assign mem_re = enter_resp && !we_d && !err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    ctr_q   <= ctr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  dmem_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (byte_enable(ctr_d[1:0], lane_d)),
    .addr (addr_d[AW+1:2]),
    .wdata(store_lanes(ctr_d[1:0], wdata_d)),
    .re   (mem_re),
    .rdata(mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? load_extend(mem_rdata, lane_q, ctr_q) : 32'h0;

endmodule
